uart_time_report_tx: RTL

- Transmit-side counterpart to the clock's UART command receiver.
- On a request, snapshots the current clock or alarm time and frames it as bytes. The bytes are serialized on a UART TX line (8N1, LSB first).
- Sits between the clock/alarm registers and the board TX pin, so the host can read back values it previously set.
- Command codes mirror the receive side: 0x01 = clock, 0x02 = alarm, 0x07 = error.

---
 rtl/uart_time_report_tx_if.sv | 23 ++
 rtl/uart_time_report_tx.sv | 127 ++++++++++++
 2 files changed

// File: rtl/uart_time_report_tx_if.sv
// Report-request side of uart_time_report_tx: time sources in, serial line and status out.
// master drives the request and time values; slave is the transmitter.
interface uart_time_report_tx_if;
  logic       req;
  logic       sel_alarm;
  logic [4:0] clk_ora;
  logic [5:0] clk_min;
  logic [4:0] alm_ora;
  logic [5:0] alm_min;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    output req, sel_alarm, clk_ora, clk_min, alm_ora, alm_min,
    input  tx, busy, done
  );

  modport slave (
    input  req, sel_alarm, clk_ora, clk_min, alm_ora, alm_min,
    output tx, busy, done
  );
endinterface

// File: rtl/uart_time_report_tx.sv
// Snapshots clock or alarm time on req and sends it as an 8N1 UART frame (LSB first).
// UART_REPORT_CHECKSUM_EN appends an XOR checksum byte to valid frames.
module uart_time_report_tx #(
  parameter int unsigned CLK_DIV = 434
) (
  input logic                  clk,
  input logic                  reset_,
  uart_time_report_tx_if.slave rpt
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

`ifdef UART_REPORT_CHECKSUM_EN
  localparam int unsigned BYTE_IDX_W = 3;
  localparam int unsigned VALID_LEN  = 4;
`else
  localparam int unsigned BYTE_IDX_W = 2;
  localparam int unsigned VALID_LEN  = 3;
`endif
  localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 1);

  state_t                state_q;
  logic [15:0]           timer_q;
  logic [2:0]            bit_q;
  logic [BYTE_IDX_W-1:0] byte_q;
  logic                  alarm_q;
  logic [4:0]            ora_q;
  logic [5:0]            min_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  done_q;

  logic       valid_d;
  logic       bit_end_d;
  logic       last_byte_d;
  logic       tx_d;
  logic [7:0] code_d;
  logic [7:0] ora_byte_d;
  logic [7:0] min_byte_d;
  logic [7:0] cur_byte_d;

  always_comb begin
    valid_d     = (ora_q <= 5'd23) && (min_q <= 6'd59);
    code_d      = alarm_q ? 8'h02 : 8'h01;
    ora_byte_d  = {3'b000, ora_q};
    min_byte_d  = {2'b00, min_q};
    bit_end_d   = (timer_q == BIT_LAST);
    last_byte_d = !valid_d || (byte_q == BYTE_IDX_W'(VALID_LEN - 1));

    cur_byte_d = 8'h07;
    if (valid_d) begin
      case (int'(byte_q))
        0:       cur_byte_d = code_d;
        1:       cur_byte_d = ora_byte_d;
        2:       cur_byte_d = min_byte_d;
`ifdef UART_REPORT_CHECKSUM_EN
        default: cur_byte_d = code_d ^ ora_byte_d ^ min_byte_d;
`else
        default: cur_byte_d = 8'h00;
`endif
      endcase
    end

    // tx is registered from the current state, so the line trails the FSM by one cycle
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte_d[bit_q];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      alarm_q <= 1'b0;
      ora_q   <= '0;
      min_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        timer_q <= '0;
        if (rpt.req) begin
          state_q <= START;
          busy_q  <= 1'b1;
          alarm_q <= rpt.sel_alarm;
          ora_q   <= rpt.sel_alarm ? rpt.alm_ora : rpt.clk_ora;
          min_q   <= rpt.sel_alarm ? rpt.alm_min : rpt.clk_min;
          byte_q  <= '0;
          bit_q   <= '0;
        end
      end else begin
        timer_q <= bit_end_d ? 16'd0 : timer_q + 16'd1;
        if (bit_end_d) begin
          case (state_q)
            START: state_q <= DATA;
            DATA: begin
              bit_q <= bit_q + 3'd1;
              if (bit_q == 3'd7) state_q <= STOP;
            end
            STOP: begin
              if (last_byte_d) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                byte_q  <= byte_q + BYTE_IDX_W'(1);
                state_q <= START;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign rpt.tx   = tx_q;
  assign rpt.busy = busy_q;
  assign rpt.done = done_q;
endmodule
